// File: rtl/morse_frame_ctrl.sv
// Morse key framer: times key marks/spaces on a 1 ms tick, assembles up to five
// dot/dash elements into a symbol and holds it for a valid/ready consumer.
module morse_frame_ctrl #(
  parameter int DOT_MAX_MS  = 1000,
  parameter int GAP_MS      = 2000,
  parameter int MARK_TMO_MS = 4000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick_1ms,
  input  logic       key,
  input  logic       sym_ready,
  output logic [9:0] sym_code,
  output logic [2:0] sym_len,
  output logic       sym_valid,
  output logic       err,
  output logic       busy
);

  typedef enum logic [2:0] {IDLE, MARK, SPACE, HOLD, ERRW} state_t;

  localparam logic [12:0] CNT_MAX  = '1;
  localparam logic [12:0] DOT_MAX  = 13'(DOT_MAX_MS);
  localparam logic [12:0] GAP      = 13'(GAP_MS);
  localparam logic [12:0] MARK_TMO = 13'(MARK_TMO_MS);
  localparam logic [2:0]  LEN_MAX  = 3'd5;

  state_t      state;
  logic [12:0] cnt;
  logic [12:0] cnt_next;
  logic [9:0]  code;
  logic [2:0]  len;
  logic        key_q;
  logic        key_rise;
  logic        key_fall;
  logic [1:0]  elem;

  // The tick of the current cycle is folded in before any edge decision uses the count.
  assign cnt_next = (tick_1ms && cnt != CNT_MAX) ? cnt + 13'd1 : cnt;
  assign key_rise = key & ~key_q;
  assign key_fall = ~key & key_q;
  assign elem     = (cnt_next >= DOT_MAX) ? 2'b11 : 2'b10;

  // NOTE: every register here uses <= so all branches see the pre-edge values;
  // a blocking assignment would leak an updated value into later decisions.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      code      <= '0;
      len       <= '0;
      key_q     <= 1'b0;
      sym_code  <= '0;
      sym_len   <= '0;
      sym_valid <= 1'b0;
      err       <= 1'b0;
      busy      <= 1'b0;
    end else begin
      key_q <= key;
      err   <= 1'b0;
      cnt   <= cnt_next;
      case (state)
        // Rising edge, not level: a key still held after a handshake is not a new mark.
        IDLE: begin
          if (key_rise) begin
            state <= MARK;
            cnt   <= '0;
            busy  <= 1'b1;
          end
        end
        MARK: begin
          if (cnt_next >= MARK_TMO) begin
            state <= ERRW;
            cnt   <= '0;
            code  <= '0;
            len   <= '0;
            err   <= 1'b1;
          end else if (key_fall) begin
            cnt <= '0;
            if (len == LEN_MAX) begin
              state <= IDLE;
              code  <= '0;
              len   <= '0;
              err   <= 1'b1;
              busy  <= 1'b0;
            end else begin
              state <= SPACE;
              if (cnt_next != '0) begin
                code <= {code[7:0], elem};
                len  <= len + 3'd1;
              end
            end
          end
        end
        SPACE: begin
          if (cnt_next >= GAP) begin
            cnt <= '0;
            if (len != '0) begin
              state     <= HOLD;
              sym_valid <= 1'b1;
              sym_code  <= code;
              sym_len   <= len;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end else if (key_rise) begin
            state <= MARK;
            cnt   <= '0;
          end
        end
        HOLD: begin
          if (sym_ready) begin
            state     <= IDLE;
            cnt       <= '0;
            code      <= '0;
            len       <= '0;
            sym_valid <= 1'b0;
            sym_code  <= '0;
            sym_len   <= '0;
            busy      <= 1'b0;
          end
        end
        ERRW: begin
          if (!key) begin
            state <= IDLE;
            cnt   <= '0;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_morse_frame_ctrl.sv
// Directed bench for morse_frame_ctrl; tick_1ms is held high so one clk = one tick
// except where a test drops it deliberately.
module tb_morse_frame_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       tick_1ms;
  logic       key;
  logic       sym_ready;
  logic [9:0] sym_code;
  logic [2:0] sym_len;
  logic       sym_valid;
  logic       err;
  logic       busy;

  int total = 0;
  int bad   = 0;

  morse_frame_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .tick_1ms  (tick_1ms),
    .key       (key),
    .sym_ready (sym_ready),
    .sym_code  (sym_code),
    .sym_len   (sym_len),
    .sym_valid (sym_valid),
    .err       (err),
    .busy      (busy)
  );

  always #10 clk = ~clk;

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic mark(input int k);
    key = 1'b1;
    step(k);
  endtask

  task automatic space(input int s);
    key = 1'b0;
    step(s);
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (!sym_valid && n < 3000) begin
      step(1);
      n++;
    end
  endtask

  task automatic handshake(input string name);
    sym_ready = 1'b1;
    step(1);
    sym_ready = 1'b0;
    total++;
    if ({sym_valid, sym_code, sym_len, busy} !== 15'd0) begin
      bad++;
      $display("FAIL %s_after_hs got valid=%0b code=%b len=%0d busy=%0b exp all 0",
               name, sym_valid, sym_code, sym_len, busy);
    end
  endtask

  task automatic expect_symbol(input string name, input logic [9:0] code, input logic [2:0] len);
    int n;
    key = 1'b0;
    wait_valid(n);
    total++;
    if (n !== 2001) begin
      bad++;
      $display("FAIL %s_gap_latency got=%0d exp=2001", name, n);
    end
    total++;
    if ({sym_valid, err, sym_code, sym_len} !== {1'b1, 1'b0, code, len}) begin
      bad++;
      $display("FAIL %s_symbol got valid=%0b err=%0b code=%b len=%0d exp valid=1 err=0 code=%b len=%0d",
               name, sym_valid, err, sym_code, sym_len, code, len);
    end
  endtask

  task automatic quiet_period(input string name, input int n);
    int seen = 0;
    for (int i = 0; i < n; i++) begin
      step(1);
      if (sym_valid || busy) seen++;
    end
    total++;
    if (seen !== 0) begin
      bad++;
      $display("FAIL %s_quiet got active_cycles=%0d exp=0", name, seen);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; key = 1'b0; tick_1ms = 1'b1; sym_ready = 1'b0;
    step(2);
    total++;
    if ({sym_valid, err, busy, sym_code, sym_len} !== 16'd0) begin
      bad++;
      $display("FAIL reset_outputs got valid=%0b err=%0b busy=%0b code=%b len=%0d exp all 0",
               sym_valid, err, busy, sym_code, sym_len);
    end
    rst = 1'b0;
    step(1);
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL reset_idle got busy=%0b exp=0", busy);
    end
  endtask

  task automatic test_dot;
    mark(300);
    expect_symbol("dot", 10'b0000000010, 3'd1);
    handshake("dot");
  endtask

  task automatic test_digit1;
    mark(300);
    space(500);
    for (int i = 0; i < 4; i++) begin
      mark(1500);
      if (i < 3) space(500);
    end
    expect_symbol("digit1", 10'b1011111111, 3'd5);
    handshake("digit1");
  endtask

  task automatic test_dot_dash_boundary;
    mark(999);
    space(500);
    mark(1000);
    expect_symbol("boundary", 10'b0000001011, 3'd2);
    handshake("boundary");
  endtask

  task automatic test_glitch;
    tick_1ms = 1'b0;
    mark(3);
    space(1);
    tick_1ms = 1'b1;
    total++;
    if (busy !== 1'b1) begin
      bad++;
      $display("FAIL glitch_space got busy=%0b exp=1", busy);
    end
    step(1999);
    total++;
    if (busy !== 1'b1) begin
      bad++;
      $display("FAIL glitch_before_gap got busy=%0b exp=1", busy);
    end
    step(1);
    total++;
    if ({busy, sym_valid} !== 2'b00) begin
      bad++;
      $display("FAIL glitch_empty_gap got busy=%0b valid=%0b exp busy=0 valid=0", busy, sym_valid);
    end
  endtask

  task automatic test_overflow;
    for (int i = 0; i < 5; i++) begin
      mark(300);
      space(500);
    end
    total++;
    if (err !== 1'b0) begin
      bad++;
      $display("FAIL overflow_fifth got err=%0b exp=0", err);
    end
    mark(300);
    space(1);
    total++;
    if ({err, busy, sym_valid} !== 3'b100) begin
      bad++;
      $display("FAIL overflow_sixth got err=%0b busy=%0b valid=%0b exp err=1 busy=0 valid=0",
               err, busy, sym_valid);
    end
    step(1);
    total++;
    if (err !== 1'b0) begin
      bad++;
      $display("FAIL overflow_err_width got err=%0b exp=0", err);
    end
    quiet_period("overflow", 2100);
  endtask

  task automatic test_timeout;
    mark(4000);
    total++;
    if ({err, busy} !== 2'b01) begin
      bad++;
      $display("FAIL timeout_before got err=%0b busy=%0b exp err=0 busy=1", err, busy);
    end
    mark(1);
    total++;
    if (err !== 1'b1) begin
      bad++;
      $display("FAIL timeout_err got err=%0b exp=1", err);
    end
    mark(1);
    total++;
    if ({err, busy} !== 2'b01) begin
      bad++;
      $display("FAIL timeout_errw got err=%0b busy=%0b exp err=0 busy=1", err, busy);
    end
    mark(998);
    space(1);
    total++;
    if ({err, busy} !== 2'b00) begin
      bad++;
      $display("FAIL timeout_release got err=%0b busy=%0b exp err=0 busy=0", err, busy);
    end
    quiet_period("timeout", 2100);
  endtask

  task automatic test_backpressure;
    mark(300);
    expect_symbol("bp", 10'b0000000010, 3'd1);
    for (int i = 0; i < 100; i++) begin
      key = ((i / 10) % 2) == 1;
      step(1);
      total++;
      if ({sym_valid, err, sym_code, sym_len} !== {1'b1, 1'b0, 10'b0000000010, 3'd1}) begin
        bad++;
        $display("FAIL bp_hold cycle=%0d got valid=%0b err=%0b code=%b len=%0d exp valid=1 err=0 code=0000000010 len=1",
                 i, sym_valid, err, sym_code, sym_len);
      end
    end
    handshake("bp");
    step(300);
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL bp_held_key got busy=%0b exp=0", busy);
    end
    key = 1'b0;
    quiet_period("bp", 2100);
  endtask

  task automatic test_reset_mid;
    mark(300);
    space(500);
    mark(300);
    space(500);
    mark(100);
    rst = 1'b1;
    step(1);
    total++;
    if ({sym_valid, err, busy, sym_code, sym_len} !== 16'd0) begin
      bad++;
      $display("FAIL rstmid_outputs got valid=%0b err=%0b busy=%0b code=%b len=%0d exp all 0",
               sym_valid, err, busy, sym_code, sym_len);
    end
    rst = 1'b0;
    step(1);
    total++;
    if (busy !== 1'b1) begin
      bad++;
      $display("FAIL rstmid_mark_start got busy=%0b exp=1", busy);
    end
    step(1499);
    expect_symbol("rstmid", 10'b0000000011, 3'd1);
    handshake("rstmid");
  endtask

  task automatic test_rst_override;
    mark(300);
    expect_symbol("override", 10'b0000000010, 3'd1);
    sym_ready = 1'b1;
    rst       = 1'b1;
    step(1);
    rst       = 1'b0;
    sym_ready = 1'b0;
    total++;
    if ({sym_valid, err, busy, sym_code, sym_len} !== 16'd0) begin
      bad++;
      $display("FAIL override_outputs got valid=%0b err=%0b busy=%0b code=%b len=%0d exp all 0",
               sym_valid, err, busy, sym_code, sym_len);
    end
    quiet_period("override", 50);
  endtask

  initial begin
    test_reset();
    test_dot();
    test_digit1();
    test_dot_dash_boundary();
    test_glitch();
    test_overflow();
    test_timeout();
    test_backpressure();
    test_reset_mid();
    test_rst_override();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
